// File: rtl/divider_aq_shift_reg.sv
// Combined A:Q register pair for a restoring divider. It supports load, a joint left shift,
// A write-back with quotient-bit insert, and a step counter with sticky done/overrun flags.
module divider_aq_shift_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] q_init,
    input  logic [WIDTH:0]   a_in,
    input  logic             q_bit,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic [CNT_W-1:0] step_cnt,
    output logic             done,
    output logic             overrun
);

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SHIFT = 2'b10,
        OP_WRITE = 2'b11
    } op_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        ovr_d  = ovr_q;
        case (op_e'(op))
            OP_LOAD: begin
                a_d    = '0;
                q_d    = q_init;
                cnt_d  = '0;
                done_d = 1'b0;
                ovr_d  = 1'b0;
            end
            OP_SHIFT: begin
                // Once done, further shifts are refused so step_cnt saturates at WIDTH.
                if (done_q) begin
                    ovr_d = 1'b1;
                end else begin
                    {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
                    cnt_d      = cnt_inc;
                    done_d     = (cnt_inc == CNT_LAST);
                end
            end
            OP_WRITE: begin
                a_d = a_in;
                q_d = {q_q[WIDTH-1:1], q_bit};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            ovr_q  <= ovr_d;
        end
    end

    assign a_out    = a_q;
    assign q_out    = q_q;
    assign step_cnt = cnt_q;
    assign done     = done_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_divider_aq_shift_reg.sv
// Bench for divider_aq_shift_reg: directed scenarios plus random divisions and a random op
// stream, all checked against arithmetic reference values computed here.
module tb_divider_aq_shift_reg;

    localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, SHIFT = 2'b10, WRITE = 2'b11;

    logic        clk;
    logic        rst_n;

    logic [1:0]  op16, op8;
    logic [15:0] qi16;
    logic [7:0]  qi8;
    logic [16:0] ai16;
    logic [8:0]  ai8;
    logic        qb16, qb8;
    logic [16:0] a16;
    logic [15:0] q16;
    logic [4:0]  cnt16;
    logic        done16, ovr16;
    logic [8:0]  a8;
    logic [7:0]  q8;
    logic [3:0]  cnt8;
    logic        done8, ovr8;

    int n_cmp = 0;
    int n_bad = 0;

    divider_aq_shift_reg #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .op(op16), .q_init(qi16), .a_in(ai16), .q_bit(qb16),
        .a_out(a16), .q_out(q16), .step_cnt(cnt16), .done(done16), .overrun(ovr16)
    );

    divider_aq_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .op(op8), .q_init(qi8), .a_in(ai8), .q_bit(qb8),
        .a_out(a8), .q_out(q8), .step_cnt(cnt8), .done(done8), .overrun(ovr8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one op to the selected instance for exactly one clock edge, then return to HOLD.
    task automatic drive(input int w, input logic [1:0] op, input logic [31:0] qi,
                         input logic [31:0] ai, input logic qb);
        if (w == 16) begin
            op16 = op; qi16 = qi[15:0]; ai16 = ai[16:0]; qb16 = qb;
        end else begin
            op8 = op; qi8 = qi[7:0]; ai8 = ai[8:0]; qb8 = qb;
        end
        @(posedge clk);
        #1;
        op16 = HOLD;
        op8  = HOLD;
    endtask

    task automatic rd(input int w, output logic [31:0] a, output logic [31:0] q,
                      output logic [31:0] c, output logic d, output logic o);
        if (w == 16) begin
            a = 32'(a16); q = 32'(q16); c = 32'(cnt16); d = done16; o = ovr16;
        end else begin
            a = 32'(a8); q = 32'(q8); c = 32'(cnt8); d = done8; o = ovr8;
        end
    endtask

    // Full restoring division; the bench plays the controller and the ALU.
    task automatic run_div(input int w, input int dividend, input int divisor);
        logic [31:0] a, q, c;
        logic        d, o;
        int          t;
        drive(w, LOAD, 32'(dividend), 0, 1'b0);
        for (int i = 0; i < w; i++) begin
            drive(w, SHIFT, 0, 0, 1'b0);
            rd(w, a, q, c, d, o);
            chk("div_done_step", 64'(d), 64'(i == w - 1));
            chk("div_cnt_step", 64'(c), 64'(i + 1));
            t = int'(a) - divisor;
            if (t < 0) drive(w, WRITE, 0, a, 1'b0);
            else       drive(w, WRITE, 0, 32'(t), 1'b1);
        end
        rd(w, a, q, c, d, o);
        chk("div_quot", 64'(q), 64'(dividend / divisor));
        chk("div_rem", 64'(a), 64'(dividend % divisor));
        chk("div_done", 64'(d), 64'd1);
        chk("div_cnt", 64'(c), 64'(w));
        $display("div w=%0d %0d/%0d -> q=%0d r=%0d", w, dividend, divisor, q, a);
    endtask

    initial begin
        logic [31:0] a, q, c, a0, q0, c0;
        logic        d, o;
        longint      m_a, m_q, v;
        int          m_cnt;
        logic        m_done, m_ovr;
        int          dvd, dvs, opsel;
        logic [1:0]  rop;
        logic [31:0] rqi, rai;
        logic        rqb;

        rst_n = 1'b0;
        op16 = HOLD; op8 = HOLD;
        qi16 = '0; qi8 = '0; ai16 = '0; ai8 = '0; qb16 = 1'b0; qb8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 64'(a16), 64'd0);
        chk("rst_done", 64'(done16), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with a non-zero A
        drive(16, WRITE, 0, 32'h1ABCD, 1'b1);
        chk("pre_rst_a", 64'(a16), 64'h1ABCD);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_a", 64'(a16), 64'd0);
        chk("async_rst_q", 64'(q16), 64'd0);
        chk("async_rst_cnt", 64'(cnt16), 64'd0);
        chk("async_rst_flags", 64'({done16, ovr16}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_a", 64'(a16), 64'd0);
        $display("reset: a=0x%0h q=0x%0h", a16, q16);

        drive(16, LOAD, 32'hA5A5, 0, 1'b0);
        chk("load_a", 64'(a16), 64'd0);
        chk("load_q", 64'(q16), 64'hA5A5);
        chk("load_cnt", 64'(cnt16), 64'd0);
        chk("load_done", 64'(done16), 64'd0);
        $display("load: q=0x%0h", q16);

        drive(16, LOAD, 32'h8001, 0, 1'b0);
        drive(16, SHIFT, 0, 0, 1'b0);
        chk("shift_a", 64'(a16), 64'h00001);
        chk("shift_q", 64'(q16), 64'h0002);
        chk("shift_cnt", 64'(cnt16), 64'd1);
        $display("shift: a=0x%0h q=0x%0h cnt=%0d", a16, q16, cnt16);

        // WRITE leaves upper Q bits, step_cnt and done alone
        drive(16, WRITE, 0, 32'h0F0F0, 1'b1);
        chk("write_a", 64'(a16), 64'h0F0F0);
        chk("write_q", 64'(q16), 64'h0003);
        chk("write_cnt", 64'(cnt16), 64'd1);

        run_div(16, 100, 7);

        rd(16, a0, q0, c0, d, o);
        drive(16, SHIFT, 0, 0, 1'b0);
        rd(16, a, q, c, d, o);
        chk("ovr_a", 64'(a), 64'(a0));
        chk("ovr_q", 64'(q), 64'(q0));
        chk("ovr_cnt", 64'(c), 64'(c0));
        chk("ovr_flag", 64'(o), 64'd1);
        drive(16, WRITE, 0, 32'h3, 1'b1);
        chk("write_after_done_a", 64'(a16), 64'h3);
        chk("write_after_done_flags", 64'({done16, ovr16}), 64'b11);
        drive(16, LOAD, 32'h1234, 0, 1'b0);
        chk("load_clr_ovr", 64'(ovr16), 64'd0);
        chk("load_clr_done", 64'(done16), 64'd0);
        $display("overrun: set then cleared by LOAD");

        run_div(8, 200, 13);

        for (int k = 0; k < 12; k++) begin
            dvd = int'($urandom_range(0, 65535));
            dvs = int'($urandom_range(1, 65535));
            run_div(16, dvd, dvs);
            dvd = int'($urandom_range(0, 255));
            dvs = int'($urandom_range(1, 255));
            run_div(8, dvd, dvs);
        end

        // Random op stream against an integer model of the A:Q pair
        drive(16, LOAD, 0, 0, 1'b0);
        m_a = 0; m_q = 0; m_cnt = 0; m_done = 1'b0; m_ovr = 1'b0;
        for (int k = 0; k < 150; k++) begin
            opsel = int'($urandom_range(0, 9));
            rop = (opsel < 5) ? SHIFT : (opsel < 7) ? WRITE : (opsel < 8) ? LOAD : HOLD;
            rqi = $urandom;
            rai = $urandom;
            rqb = 1'($urandom);
            case (rop)
                LOAD: begin
                    m_a = 0; m_q = longint'(rqi[15:0]); m_cnt = 0; m_done = 1'b0; m_ovr = 1'b0;
                end
                SHIFT: begin
                    if (m_done) m_ovr = 1'b1;
                    else begin
                        v = ((m_a * 65536 + m_q) * 2) % (longint'(1) << 33);
                        m_a = v / 65536;
                        m_q = v % 65536;
                        m_cnt++;
                        m_done = (m_cnt == 16);
                    end
                end
                WRITE: begin
                    m_a = longint'(rai[16:0]);
                    m_q = (m_q / 2) * 2 + longint'(rqb);
                end
                default: ;
            endcase
            drive(16, rop, rqi, rai, rqb);
            rd(16, a, q, c, d, o);
            chk("rnd_a", 64'(a), 64'(m_a));
            chk("rnd_q", 64'(q), 64'(m_q));
            chk("rnd_cnt", 64'(c), 64'(m_cnt));
            chk("rnd_flags", 64'({d, o}), 64'({m_done, m_ovr}));
            $display("rnd op=%0d a=0x%0h q=0x%0h cnt=%0d done=%0b ovr=%0b", rop, a, q, c, d, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
